decoder_sweep_gen: RTL

DECODER_SWEEP_GEN -- requirements
Module: decoder_sweep_gen

---
 rtl/decoder_sweep_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decoder_sweep_gen.sv
// decoder_sweep_gen: exhaustive / opcode-range stimulus sweeper for an instruction decoder.
// Presents each sweep counter value as a differential vector on `a` with a valid/ready handshake.
// Optional response signature: define DECODER_SWEEP_MISR_EN to build the 32-bit MISR over cap_data;
// without it, signature is constant zero and cap_data is ignored.
//
// state | meaning
// IDLE  | waiting for start; cnt holds (0 after reset/abort)
// RUN   | vector on a/cnt is valid; advances on each handshake
// DONE  | one-cycle completion pulse, then back to IDLE
module decoder_sweep_gen #(
    parameter int IR_W    = 8,
    parameter int STATE_W = 3,
    parameter int SIG_W   = 214,
    localparam int CNT_W  = IR_W + STATE_W + 4,
    localparam int A_W    = 4 + 2*IR_W + 2*STATE_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic               cfg_intr,
    input  logic               cfg_cb,
    input  logic [IR_W-1:0]    ir_lo,
    input  logic [IR_W-1:0]    ir_hi,
    input  logic               vec_ready,
    input  logic [SIG_W-1:0]   cap_data,
    output logic [A_W-1:0]     a,
    output logic [CNT_W-1:0]   cnt,
    output logic               vec_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W:0]     vec_count,
    output logic [31:0]        signature
);

    // writeback + data_lsb + state bits sweep below the opcode field
    localparam int LOW_W = STATE_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W:0]   VC_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] last_cnt;

    // Differential vector: intr, cb, then opcode and state bits MSB first, each as (~bit, bit)
    always_comb begin
        a    = '0;
        a[0] = ~cnt[CNT_W-1];
        a[1] =  cnt[CNT_W-1];
        a[2] = ~cnt[CNT_W-2];
        a[3] =  cnt[CNT_W-2];
        for (int k = 0; k < IR_W; k++) begin
            a[4+2*k] = ~cnt[LOW_W+IR_W-1-k];
            a[5+2*k] =  cnt[LOW_W+IR_W-1-k];
        end
        for (int k = 0; k < STATE_W; k++) begin
            a[4+2*IR_W+2*k] = ~cnt[STATE_W+1-k];
            a[5+2*IR_W+2*k] =  cnt[STATE_W+1-k];
        end
    end

    // Sweep sequencer; the last vector is frozen into last_cnt at start so config changes mid-run are inert
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            last_cnt  <= '0;
            vec_count <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        vec_count <= '0;
                        if (mode && (ir_lo > ir_hi)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            vec_valid <= 1'b1;
                            busy      <= 1'b1;
                            if (mode) begin
                                cnt      <= {cfg_intr, cfg_cb, ir_lo, {LOW_W{1'b0}}};
                                last_cnt <= {cfg_intr, cfg_cb, ir_hi, {LOW_W{1'b1}}};
                            end else begin
                                cnt      <= '0;
                                last_cnt <= '1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (vec_ready) begin
                        vec_count <= vec_count + VC_ONE;
                        if (cnt == last_cnt) begin
                            state     <= DONE;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    vec_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_SWEEP_MISR_EN
    localparam int N_CHUNK = (SIG_W + 31) / 32;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic [N_CHUNK*32-1:0] cap_pad;
    logic [31:0]           fold;

    // Fold the response into one word: XOR of 32-bit chunks, top chunk zero-padded
    always_comb begin
        cap_pad              = '0;
        cap_pad[SIG_W-1:0]   = cap_data;
        fold                 = '0;
        for (int i = 0; i < N_CHUNK; i++) begin
            fold = fold ^ cap_pad[i*32 +: 32];
        end
    end

    // CRC-style MISR: seeded at start, stepped once per accepted vector
    always_ff @(posedge CLK) begin
        if (RESET) begin
            signature <= '0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                signature <= 32'hFFFF_FFFF;
            end else if (state == RUN && vec_ready) begin
                signature <= {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
            end
        end
    end
`else
    logic unused_cap;
    assign unused_cap = ^cap_data;
    assign signature  = '0;
`endif

endmodule
